// File: rtl/perf_counter_pkg.sv
// Shared encodings for the performance-counter control master: command ops,
// FSM states and the slave word map.
package perf_counter_pkg;

  typedef enum logic [1:0] {
    OP_START        = 2'b00,
    OP_STOP         = 2'b01,
    OP_GLOBAL_RESET = 2'b10,
    OP_READ         = 2'b11
  } cmd_op_t;

  // ST_RD4 is only reached when the tear-retry read sequence is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_RD4,
    ST_RESP
  } pcm_state_t;

  localparam int unsigned OFF_STOP_LO       = 0;
  localparam int unsigned OFF_GO_HI         = 1;
  localparam int unsigned OFF_EVENT         = 2;
  localparam int unsigned SECTION_STRIDE    = 4;
  localparam int unsigned GLOBAL_RESET_DATA = 1;

  // Word address of a register within a counter section.
  function automatic int unsigned word_addr(input logic [2:0] sec,
                                            input int unsigned off);
    return int'(sec) * SECTION_STRIDE + off;
  endfunction

endpackage

// File: rtl/perf_counter_master.sv
// Avalon-MM master that issues start/stop/global-reset writes and 64-bit
// time + 32-bit event reads to the 8-section performance-counter slave.
// Optional feature macro: PERF_COUNTER_MASTER_TEAR_RETRY_EN
//   defined   : read order hi/lo/hi/events, retried up to 3 attempts on a
//               high-word mismatch, res_err flags an unresolved tear.
//   undefined : plain lo/hi/events read order.
module perf_counter_master
  import perf_counter_pkg::*;
#(
  parameter int unsigned NUM_SECTIONS = 8,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_section,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2:0]        res_section,
  output logic [63:0]       res_time,
  output logic [31:0]       res_events,
  output logic              res_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic              avm_begintransfer,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy
);

  pcm_state_t  state_q, state_d;
  cmd_op_t     op_q;
  logic [2:0]  sec_q;
  logic [63:0] res_time_q;
  logic [31:0] res_events_q;
  logic        res_err_q;
  logic [2:0]  res_section_q;
  logic        cmd_fire;
  logic        sec_in_range;
  logic [31:0] rdata32;

`ifdef PERF_COUNTER_MASTER_TEAR_RETRY_EN
  logic [31:0] h1_q;
  logic [1:0]  try_q;
`endif

  assign res_valid    = (state_q == ST_RESP);
  assign cmd_ready    = (state_q == ST_IDLE) && !res_valid;
  assign busy         = (state_q != ST_IDLE);
  assign cmd_fire     = cmd_valid && cmd_ready;
  assign sec_in_range = (32'(cmd_section) < NUM_SECTIONS);
  assign rdata32      = 32'(avm_readdata);

  assign res_time    = res_time_q;
  assign res_events  = res_events_q;
  assign res_err     = res_err_q;
  assign res_section = res_section_q;

  // State register; reset aborts any bus cycle and drops pending results.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and bus strobes/address/data; bus is idle-zero.
  always_comb begin
    state_d           = state_q;
    avm_write         = 1'b0;
    avm_read          = 1'b0;
    avm_begintransfer = 1'b0;
    avm_address       = '0;
    avm_writedata     = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (!sec_in_range)
            state_d = (cmd_op == OP_READ) ? ST_RESP : ST_IDLE;
          else
            state_d = (cmd_op == OP_READ) ? ST_RD0 : ST_WR;
        end
      end
      ST_WR: begin
        avm_write         = 1'b1;
        avm_begintransfer = 1'b1;
        if (op_q == OP_GLOBAL_RESET) begin
          avm_address   = '0;
          avm_writedata = DATA_W'(GLOBAL_RESET_DATA);
        end else begin
          avm_address = ADDR_W'(word_addr(sec_q,
                          (op_q == OP_START) ? OFF_GO_HI : OFF_STOP_LO));
        end
        state_d = ST_IDLE;
      end
`ifdef PERF_COUNTER_MASTER_TEAR_RETRY_EN
      ST_RD0: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = ADDR_W'(word_addr(sec_q, OFF_GO_HI));
        state_d = ST_RD1;
      end
      ST_RD1: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = ADDR_W'(word_addr(sec_q, OFF_STOP_LO));
        state_d = ST_RD2;
      end
      ST_RD2: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = ADDR_W'(word_addr(sec_q, OFF_GO_HI));
        state_d = ST_RD3;
      end
      ST_RD3: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = ADDR_W'(word_addr(sec_q, OFF_EVENT));
        state_d = ST_RD4;
      end
      ST_RD4: begin
        // H1 is in h1_q, H2 already landed in the upper time word.
        if ((h1_q == res_time_q[63:32]) || (try_q == 2'd2)) state_d = ST_RESP;
        else                                                 state_d = ST_RD0;
      end
`else
      ST_RD0: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = ADDR_W'(word_addr(sec_q, OFF_STOP_LO));
        state_d = ST_RD1;
      end
      ST_RD1: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = ADDR_W'(word_addr(sec_q, OFF_GO_HI));
        state_d = ST_RD2;
      end
      ST_RD2: begin
        avm_read = 1'b1; avm_begintransfer = 1'b1;
        avm_address = ADDR_W'(word_addr(sec_q, OFF_EVENT));
        state_d = ST_RD3;
      end
      ST_RD3: state_d = ST_RESP;
`endif
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch and read-data capture; readdata lags the address by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q          <= OP_START;
      sec_q         <= '0;
      res_time_q    <= '0;
      res_events_q  <= '0;
      res_err_q     <= 1'b0;
      res_section_q <= '0;
`ifdef PERF_COUNTER_MASTER_TEAR_RETRY_EN
      h1_q          <= '0;
      try_q         <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            op_q  <= cmd_op_t'(cmd_op);
            sec_q <= cmd_section;
            if (cmd_op == OP_READ) begin
              res_section_q <= cmd_section;
              res_time_q    <= '0;
              res_events_q  <= '0;
              res_err_q     <= !sec_in_range;
            end
`ifdef PERF_COUNTER_MASTER_TEAR_RETRY_EN
            try_q <= '0;
`endif
          end
        end
`ifdef PERF_COUNTER_MASTER_TEAR_RETRY_EN
        ST_RD1: h1_q               <= rdata32;
        ST_RD2: res_time_q[31:0]   <= rdata32;
        ST_RD3: res_time_q[63:32]  <= rdata32;
        ST_RD4: begin
          res_events_q <= rdata32;
          if (h1_q != res_time_q[63:32]) begin
            if (try_q == 2'd2) res_err_q <= 1'b1;
            else               try_q     <= try_q + 2'd1;
          end
        end
`else
        ST_RD1: res_time_q[31:0]  <= rdata32;
        ST_RD2: res_time_q[63:32] <= rdata32;
        ST_RD3: res_events_q      <= rdata32;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_master.sv
// Directed bench for perf_counter_master with a latency-1 slave model.
module tb_perf_counter_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_valid_b;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_section;
  logic        res_ready;

  logic        cmd_ready, res_valid, res_err, avm_write, avm_read, avm_bt, busy;
  logic [2:0]  res_section;
  logic [63:0] res_time;
  logic [31:0] res_events, avm_wdata, sl_rdata;
  logic [4:0]  avm_addr;

  logic        cmd_ready_b, res_valid_b, res_err_b, avm_write_b, avm_read_b, avm_bt_b, busy_b;
  logic [2:0]  res_section_b;
  logic [63:0] res_time_b;
  logic [31:0] res_events_b, avm_wdata_b;
  logic [31:0] zero_rdata = 32'h0;
  logic [4:0]  avm_addr_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  perf_counter_master #(.NUM_SECTIONS(8), .ADDR_W(5), .DATA_W(32)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_section(cmd_section), .res_valid(res_valid),
    .res_ready(res_ready), .res_section(res_section), .res_time(res_time),
    .res_events(res_events), .res_err(res_err), .avm_address(avm_addr),
    .avm_write(avm_write), .avm_read(avm_read), .avm_begintransfer(avm_bt),
    .avm_writedata(avm_wdata), .avm_readdata(sl_rdata), .busy(busy));

  perf_counter_master #(.NUM_SECTIONS(4), .ADDR_W(5), .DATA_W(32)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .cmd_section(cmd_section), .res_valid(res_valid_b),
    .res_ready(res_ready), .res_section(res_section_b), .res_time(res_time_b),
    .res_events(res_events_b), .res_err(res_err_b), .avm_address(avm_addr_b),
    .avm_write(avm_write_b), .avm_read(avm_read_b), .avm_begintransfer(avm_bt_b),
    .avm_writedata(avm_wdata_b), .avm_readdata(zero_rdata), .busy(busy_b));

  // Slave model: fixed read latency 1. Once hi_cnt reaches tear_thr the
  // tear section's time value reads one higher (low word wraps to 0).
  logic [63:0] sl_time [8];
  logic [31:0] sl_ev   [8];
  int unsigned hi_cnt = 0;
  int unsigned rd_cnt = 0;
  int unsigned tear_thr = 32'hFFFF_FFFF;
  logic [2:0]  tear_sec = 3'd1;
  logic [63:0] t_now;
  logic [2:0]  s_now;

  always @(posedge clk) begin
    if (avm_read) begin
      s_now = avm_addr[4:2];
      t_now = sl_time[s_now] + ((s_now == tear_sec && hi_cnt >= tear_thr) ? 64'd1 : 64'd0);
      case (avm_addr[1:0])
        2'd0:    sl_rdata <= t_now[31:0];
        2'd1:    sl_rdata <= t_now[63:32];
        2'd2:    sl_rdata <= sl_ev[s_now];
        default: sl_rdata <= 32'h0;
      endcase
      if (avm_addr[1:0] == 2'd1) hi_cnt <= hi_cnt + 1;
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [4:0]  exp_addr [4];
  int          nrd;
  logic [4:0]  rd2_addr;
  int unsigned rd_snap;
  bit          got;

  initial begin
    for (int i = 0; i < 8; i++) begin
      sl_time[i] = 64'h0;
      sl_ev[i]   = 32'h0;
    end
    sl_time[5] = 64'h0000_0003_0000_0010;
    sl_ev[5]   = 32'd7;
    sl_time[1] = 64'h0000_0003_FFFF_FFFF;
    sl_ev[1]   = 32'h55;
    sl_rdata   = 32'h0;
`ifdef PERF_COUNTER_MASTER_TEAR_RETRY_EN
    exp_addr = '{5'd21, 5'd20, 5'd21, 5'd22}; nrd = 4; rd2_addr = 5'd21;
`else
    exp_addr = '{5'd20, 5'd21, 5'd22, 5'd0};  nrd = 3; rd2_addr = 5'd22;
`endif
    reset = 1'b1; cmd_valid = 1'b0; cmd_valid_b = 1'b0;
    cmd_op = 2'b00; cmd_section = 3'd0; res_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {avm_write, avm_read, avm_bt}, 0);
    chk("rst_addr", avm_addr, 0);
    chk("rst_res_time", res_time, 0);
    reset = 1'b0;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);

    // START section 2 -> write address 9, data 0
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_section = 3'd2;
    tick();
    cmd_valid = 1'b0;
    chk("start_wr", {avm_write, avm_bt, avm_read}, 3'b110);
    chk("start_addr", avm_addr, 9);
    chk("start_data", avm_wdata, 0);
    chk("start_cmd_ready", cmd_ready, 0);
    chk("start_busy", busy, 1);
    tick();
    chk("start_done_wr", avm_write, 0);
    chk("start_done_addr", avm_addr, 0);
    chk("start_done_ready", cmd_ready, 1);

    // GLOBAL_RESET -> address 0, data 1
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_section = 3'd3;
    tick();
    cmd_valid = 1'b0;
    chk("gr_wr", avm_write, 1);
    chk("gr_addr", avm_addr, 0);
    chk("gr_data", avm_wdata, 1);
    tick();

    // STOP section 0 -> address 0, data 0
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_section = 3'd0;
    tick();
    cmd_valid = 1'b0;
    chk("stop0_wr", avm_write, 1);
    chk("stop0_addr", avm_addr, 0);
    chk("stop0_data", avm_wdata, 0);
    tick();

    // STOP section 7 (last section) -> address 28
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_section = 3'd7;
    tick();
    cmd_valid = 1'b0;
    chk("stop7_addr", avm_addr, 28);
    tick();

    // res_ready while idle is ignored
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("stray_ready_busy", busy, 0);

    // READ section 5
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_section = 3'd5;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < nrd; i++) begin
      chk("rd_strobe", {avm_read, avm_bt, avm_write}, 3'b110);
      chk("rd_addr", avm_addr, exp_addr[i]);
      chk("rd_not_valid", res_valid, 0);
      tick();
    end
    chk("rd_capture_idle_bus", {avm_read, avm_write}, 0);
    chk("rd_capture_not_valid", res_valid, 0);
    tick();
    chk("rd_valid", res_valid, 1);
    chk("rd_time", res_time, 64'h0000_0003_0000_0010);
    chk("rd_events", res_events, 7);
    chk("rd_section", res_section, 5);
    chk("rd_err", res_err, 0);

    // Backpressure: results stay, new command not accepted
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_section = 3'd1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_time", res_time, 64'h0000_0003_0000_0010);
      chk("hold_events", res_events, 7);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_no_bus", {avm_write, avm_read}, 0);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("resp_drop_valid", res_valid, 0);
    chk("resp_drop_ready", cmd_ready, 1);
    chk("resp_drop_busy", busy, 0);
    tick();
    chk("held_cmd_dropped", avm_write, 0);

    // NUM_SECTIONS=4: READ section 6 out of range
    cmd_valid_b = 1'b1; cmd_op = 2'b11; cmd_section = 3'd6;
    tick();
    cmd_valid_b = 1'b0;
    chk("oor_rd_no_bus", {avm_read_b, avm_write_b}, 0);
    chk("oor_rd_valid", res_valid_b, 1);
    chk("oor_rd_err", res_err_b, 1);
    chk("oor_rd_time", res_time_b, 0);
    chk("oor_rd_events", res_events_b, 0);
    chk("oor_rd_section", res_section_b, 6);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("oor_rd_release", res_valid_b, 0);

    // NUM_SECTIONS=4: STOP section 6 -> no bus cycle
    cmd_valid_b = 1'b1; cmd_op = 2'b01; cmd_section = 3'd6;
    tick();
    cmd_valid_b = 1'b0;
    chk("oor_stop_no_bus", {avm_read_b, avm_write_b}, 0);
    chk("oor_stop_idle", busy_b, 0);
    chk("oor_stop_ready", cmd_ready_b, 1);

    // NUM_SECTIONS=4: START section 3 is in range -> address 13
    cmd_valid_b = 1'b1; cmd_op = 2'b00; cmd_section = 3'd3;
    tick();
    cmd_valid_b = 1'b0;
    chk("b_start3_wr", avm_write_b, 1);
    chk("b_start3_addr", avm_addr_b, 13);
    tick();

    // Reset during RD2
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_section = 3'd5;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("rd2_before_rst", {avm_read, avm_addr}, {1'b1, rd2_addr});
    reset = 1'b1;
    tick();
    chk("rst_mid_strobes", {avm_read, avm_write, avm_bt}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", res_valid, 0);
    reset = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("rst_mid_discard", res_valid, 0);
    chk("rst_mid_idle", busy, 0);

`ifdef PERF_COUNTER_MASTER_TEAR_RETRY_EN
    // Low word wraps between H1 and H2 on the first attempt
    tear_thr = hi_cnt + 1;
    rd_snap  = rd_cnt;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_section = 3'd1;
    tick();
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (res_valid) got = 1'b1;
      else tick();
    end
    chk("tear_wait", got, 1);
    chk("tear_time", res_time, 64'h0000_0004_0000_0000);
    chk("tear_err", res_err, 0);
    chk("tear_events", res_events, 32'h55);
    chk("tear_reads", rd_cnt - rd_snap, 8);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/perf_counter_master.md
Name: perf_counter_master

Overview:
- Avalon-MM master that drives the 8-section performance-counter control slave from hardware, so that non-Nios logic (e.g. the cruise-control loop) can bracket code or hardware regions without CPU involvement.
- It accepts start, stop, global-reset and read commands on a valid/ready interface, then generates the matching slave bus cycles.
- For a read, it collects the 64-bit time count and the 32-bit event count and returns them on a valid/ready result interface.
- It sits beside the CPU data master on the same slave port, through the system interconnect.

Parameters:
- NUM_SECTIONS, 8, number of counter sections implemented in the slave (1..8).
- ADDR_W, 5, slave word-address width.
- DATA_W, 32, bus data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_op  in  2  00 START, 01 STOP, 10 GLOBAL_RESET, 11 READ
- cmd_section  in  3  target section index
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_section  out  3  section of the result
- res_time  out  64  time counter value
- res_events  out  32  event counter value
- res_err  out  1  section index out of range
- avm_address  out  ADDR_W  slave word address
- avm_write  out  1  write strobe
- avm_read  out  1  read strobe
- avm_begintransfer  out  1  first cycle of every transfer
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  slave read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - All outputs 0, except cmd_ready = 1.
  - FSM in IDLE.
- Reset mid-operation: the bus cycle is aborted (strobes low on the next edge) and any pending or in-flight result is discarded.
- Address map for section s: base = 4*s.
  - STOP write to base+0; START write to base+1.
  - GLOBAL_RESET is a write to address 0 with writedata = 1. STOP of section 0 writes data 0.
  - Reads: time low at base+0, time high at base+1, events at base+2.
- Slave timing: the slave has no waitrequest and a fixed read latency of 1. avm_readdata in cycle N+1 reflects avm_address presented in cycle N.
- cmd_ready = (state == IDLE) and not res_valid.
- States and transitions:
  - IDLE: on accept, latch op and section.
    - If cmd_section >= NUM_SECTIONS: READ goes to RESP with res_err = 1 and zero data; other ops return to IDLE with no bus cycle.
    - START/STOP/GLOBAL_RESET go to WR.
    - READ goes to RD0.
  - WR: one cycle with avm_write = 1, avm_begintransfer = 1 and address/data per the map, then IDLE. A write command occupies exactly 2 cycles from acceptance until cmd_ready is high again.
  - RD0: avm_read = 1, begintransfer = 1, address = base+0.
  - RD1: address = base+1; capture time[31:0].
  - RD2: address = base+2; capture time[63:32].
  - RD3: strobes low; capture events.
  - RESP: res_valid = 1. Hold all res_* stable until res_ready. On handshake, go to IDLE and drop res_valid on the next edge.
- Read timing: 4 bus-active/capture cycles after acceptance. res_valid rises on the 5th edge after acceptance.
- Simultaneous events:
  - A new command presented while res_valid = 1 is not accepted.
  - res_ready while res_valid = 0 is ignored.
- avm_read and avm_write are never high in the same cycle.
- avm_address, avm_writedata are 0 whenever no strobe is asserted.

Optional Feature:
- Macro: PERF_COUNTER_MASTER_TEAR_RETRY_EN.
- When defined, the READ sequence is: time high (H1), time low, time high (H2), events.
  - If H1 != H2, the sequence restarts, up to 3 attempts.
  - After 3 mismatching attempts, the last values are returned with res_err = 1.
  - Without a mismatch, read latency is one cycle longer than the base READ sequence.
- When undefined, the plain lo/hi/events sequence applies and a carry between the two time reads can tear the 64-bit value.

Decomposition:
- Shared package perf_counter_pkg:
  - cmd_op encoding constants.
  - FSM state enum.
  - Word offsets: OFF_STOP_LO = 0, OFF_GO_HI = 1, OFF_EVENT = 2, SECTION_STRIDE = 4.
  - GLOBAL_RESET_DATA = 1.
- No sub-module: a single FSM plus capture registers.

Test Plan:
- START section 2 -> one cycle with write = 1, begintransfer = 1, address = 9, writedata = 0; cmd_ready low for 2 cycles, then high.
- GLOBAL_RESET -> write to address 0, writedata = 1; STOP section 0 -> address 0, writedata = 0.
- READ section 5 against a slave model returning time = 0x0000_0003_0000_0010 and events = 7:
  - bus reads at addresses 20, 21, 22;
  - res_valid on the 5th edge with res_time = 0x0000_0003_0000_0010, res_events = 7, res_section = 5.
- Hold res_ready = 0 for 10 cycles -> res_* stable and cmd_ready = 0. A new command in that window is not accepted.
- NUM_SECTIONS = 4, READ section 6 -> no bus activity; res_err = 1, data 0. STOP section 6 -> no bus activity, returns to IDLE.
- Assert reset during RD2 -> next cycle all strobes 0, busy = 0, res_valid = 0.
- TEAR_RETRY_EN: model the time low word wrapping 0xFFFF_FFFF -> 0 between reads -> H1 != H2, the sequence retries, and a consistent 64-bit value is returned with res_err = 0.
